id_scoreboard: RTL and testbench

- Decode-stage hazard unit that sits directly upstream of the register file (rf) read ports.
- Tracks destination registers of in-flight instructions in EX, MEM and WB through a 3-entry shift pipeline.
- Compares them against the decoding instruction's source addresses (the same p0_addr/p1_addr/re0/re1 driven into rf) and asserts stall for RAW hazards.
- Keeps a saturating stall-cycle counter for debug dump at hlt.

---
 rtl/id_scoreboard.sv | 134 +++++++++++++
 tb/tb_id_scoreboard.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage RAW hazard detector placed ahead of the
// register file read ports. It tracks the destinations of instructions in
// EX, MEM and WB and stalls the decoding instruction when a source is not
// yet readable. It also keeps a saturating count of stall cycles.
// Optional build macro SCOREBOARD_FWD_EN adds bypass selects and restricts
// stalls to load-use hazards.
module id_scoreboard #(
  parameter int CNT_W = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    p0_addr,
  input  logic [AW-1:0]    p1_addr,
  input  logic             re0,
  input  logic             re1,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [AW-1:0]    issue_dst_addr,
  input  logic             issue_is_load,
  input  logic             flush,
  input  logic             hlt,
  output logic             stall,
  output logic [1:0]       fwd0_sel,
  output logic [1:0]       fwd1_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic          exVld_q, exWe_q, exLd_q;
  logic [AW-1:0] exAddr_q;
  logic          memVld_q, memWe_q, memLd_q;
  logic [AW-1:0] memAddr_q;
  logic          wbVld_q, wbWe_q, wbLd_q;
  logic [AW-1:0] wbAddr_q;

  logic          exVld_d, exWe_d, exLd_d;
  logic [AW-1:0] exAddr_d;
  logic          memVld_d, memWe_d, memLd_d;
  logic [AW-1:0] memAddr_d;

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic hit0Ex, hit0Mem, hit1Ex, hit1Mem;

  // WB contents and the halt strobe never influence hazard decisions:
  // the register file writes in the first half-cycle and reads in the second.
  logic unusedBits;
  assign unusedBits = ^{hlt, wbVld_q, wbWe_q, wbAddr_q, wbLd_q, exLd_q};

  // Source/stage match; R0 is hardwired zero so it can never be a hazard.
  always_comb begin
    hit0Ex  = re0 & exVld_q  & exWe_q  & (exAddr_q  == p0_addr) & (|p0_addr);
    hit0Mem = re0 & memVld_q & memWe_q & (memAddr_q == p0_addr) & (|p0_addr);
    hit1Ex  = re1 & exVld_q  & exWe_q  & (exAddr_q  == p1_addr) & (|p1_addr);
    hit1Mem = re1 & memVld_q & memWe_q & (memAddr_q == p1_addr) & (|p1_addr);
  end

`ifdef SCOREBOARD_FWD_EN
  // With bypassing only a load still in EX cannot be forwarded in time.
  always_comb begin
    stall    = issue_valid & ~flush & exLd_q & (hit0Ex | hit1Ex);
    fwd0_sel = hit0Ex ? 2'd1 : (hit0Mem ? 2'd2 : 2'd0);
    fwd1_sel = hit1Ex ? 2'd1 : (hit1Mem ? 2'd2 : 2'd0);
  end
`else
  // Without bypassing any producer still in EX or MEM blocks the read.
  always_comb begin
    stall    = issue_valid & ~flush & (hit0Ex | hit0Mem | hit1Ex | hit1Mem);
    fwd0_sel = 2'd0;
    fwd1_sel = 2'd0;
  end
`endif

  // Next stage contents: flush squashes both decode and EX, so neither advances.
  always_comb begin
    exVld_d   = issue_valid & ~stall & ~flush;
    exWe_d    = issue_we;
    exAddr_d  = issue_dst_addr;
    exLd_d    = issue_is_load;
    memVld_d  = exVld_q & ~flush;
    memWe_d   = exWe_q;
    memAddr_d = exAddr_q;
    memLd_d   = exLd_q;
  end

  // Saturating count of cycles spent stalled.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != {CNT_W{1'b1}}))
      stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Shift the in-flight destination pipeline; reset drops every pending hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exVld_q   <= 1'b0;
      exWe_q    <= 1'b0;
      exAddr_q  <= '0;
      exLd_q    <= 1'b0;
      memVld_q  <= 1'b0;
      memWe_q   <= 1'b0;
      memAddr_q <= '0;
      memLd_q   <= 1'b0;
      wbVld_q   <= 1'b0;
      wbWe_q    <= 1'b0;
      wbAddr_q  <= '0;
      wbLd_q    <= 1'b0;
    end else begin
      exVld_q   <= exVld_d;
      exWe_q    <= exWe_d;
      exAddr_q  <= exAddr_d;
      exLd_q    <= exLd_d;
      memVld_q  <= memVld_d;
      memWe_q   <= memWe_d;
      memAddr_q <= memAddr_d;
      memLd_q   <= memLd_d;
      wbVld_q   <= memVld_q;
      wbWe_q    <= memWe_q;
      wbAddr_q  <= memAddr_q;
      wbLd_q    <= memLd_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stallCnt_q <= '0;
    else
      stallCnt_q <= stallCnt_d;
  end

  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed-vector bench for id_scoreboard. The stimulus
// process pushes hand-computed expectations into a queue; a separate monitor
// pops and compares them against the DUT outputs mid-cycle.
module tb_id_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  p0_addr, p1_addr, issue_dst_addr;
  logic        re0, re1, issue_valid, issue_we, issue_is_load, flush, hlt;
  logic        stall;
  logic [1:0]  fwd0_sel, fwd1_sel;
  logic [15:0] stall_cnt;

  typedef struct {
    logic        stall;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cntModel = 16'd0;
  logic        lastExpStall = 1'b0;
  event        checkNow;

  id_scoreboard #(.CNT_W(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_dst_addr(issue_dst_addr), .issue_is_load(issue_is_load),
    .flush(flush), .hlt(hlt),
    .stall(stall), .fwd0_sel(fwd0_sel), .fwd1_sel(fwd1_sel),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge hlt) $display("[TB] hlt: stall_cnt=%0d", stall_cnt);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({stall, fwd0_sel, fwd1_sel, stall_cnt} !== {e.stall, e.f0, e.f1, e.cnt}) begin
      errors++;
      $display("[TB] FAIL %s: got stall=%0b fwd0=%0d fwd1=%0d cnt=%0d, expected stall=%0b fwd0=%0d fwd1=%0d cnt=%0d",
               e.name, stall, fwd0_sel, fwd1_sel, stall_cnt, e.stall, e.f0, e.f1, e.cnt);
    end
  endtask

  // Monitor: compare whatever expectations are pending once outputs settle.
  initial begin
    forever begin
      @(negedge clk or checkNow);
      #1;
      while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic pushExp(input string name, input logic s, input logic [1:0] f0,
                         input logic [1:0] f1);
    exp_t e;
    e.stall = s; e.f0 = f0; e.f1 = f1; e.cnt = cntModel; e.name = name;
    expQ.push_back(e);
    lastExpStall = s;
  endtask

  task automatic applyStimulus(input string name, input logic v, input logic we,
                               input logic [3:0] dst, input logic ld,
                               input logic r0, input logic [3:0] a0,
                               input logic r1, input logic [3:0] a1,
                               input logic fl, input logic eS,
                               input logic [1:0] eF0, input logic [1:0] eF1);
    @(posedge clk);
    #1;
    if (lastExpStall && cntModel != 16'hFFFF) cntModel = cntModel + 16'd1;
    issue_valid = v; issue_we = we; issue_dst_addr = dst; issue_is_load = ld;
    re0 = r0; p0_addr = a0; re1 = r1; p1_addr = a1; flush = fl;
    pushExp(name, eS, eF0, eF1);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_we = 0; issue_dst_addr = 0; issue_is_load = 0;
    re0 = 0; p0_addr = 0; re1 = 0; p1_addr = 0; flush = 0; hlt = 0;
    #7;
    pushExp("reset_state", 1'b0, 2'd0, 2'd0);
    -> checkNow;
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef SCOREBOARD_FWD_EN
    applyStimulus("ld_r4",        1,1,4,1, 0,0,0,0, 0, 0,0,0);
    applyStimulus("load_use",     1,1,5,0, 0,0,1,4, 0, 1,0,1);
    applyStimulus("load_fwd_mem", 1,1,5,0, 0,0,1,4, 0, 0,0,2);
    applyStimulus("alu_r4_fwd_ex",1,1,4,0, 1,5,0,0, 0, 0,1,0);
    applyStimulus("fwd_ex_mem",   1,0,0,0, 1,5,1,4, 0, 0,2,1);
    applyStimulus("wr_r0",        1,1,0,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("rd_r0_nofwd",  1,0,0,0, 1,0,1,0, 0, 0,0,0);
    applyStimulus("wr_r3_a",      1,1,3,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("wr_r3_b",      1,1,3,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("ex_priority",  1,0,0,0, 1,3,0,0, 0, 0,1,0);
`else
    applyStimulus("add_r3",       1,1,3,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("sub_raw_ex",   1,1,7,0, 1,3,0,0, 0, 1,0,0);
    applyStimulus("sub_raw_mem",  1,1,7,0, 1,3,0,0, 0, 1,0,0);
    applyStimulus("sub_go",       1,1,7,0, 1,3,0,0, 0, 0,0,0);
    applyStimulus("no_valid",     0,0,0,0, 1,7,0,0, 0, 0,0,0);
    applyStimulus("drain",        0,0,0,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("wr_r0",        1,1,0,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("rd_r0_ex",     1,0,0,0, 1,0,1,0, 0, 0,0,0);
    applyStimulus("rd_r0_mem",    1,0,0,0, 1,0,1,0, 0, 0,0,0);
    applyStimulus("wr_r5",        1,1,5,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("indep_a",      1,1,8,0, 1,1,0,0, 0, 0,0,0);
    applyStimulus("indep_b",      1,1,9,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("rd_r5_in_wb",  1,0,0,0, 1,5,1,5, 0, 0,0,0);
    applyStimulus("re_masked",    1,0,0,0, 0,9,0,9, 0, 0,0,0);
    applyStimulus("wr_r10",       1,1,10,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("both_ex",      1,0,0,0, 1,10,1,10, 0, 1,0,0);
    applyStimulus("both_mem",     1,0,0,0, 1,10,1,10, 0, 1,0,0);
    applyStimulus("both_go",      1,0,0,0, 1,10,1,10, 0, 0,0,0);
    applyStimulus("wr_r11",       1,1,11,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("src1_ex",      1,0,0,0, 1,2,1,11, 0, 1,0,0);
    applyStimulus("src1_mem",     1,0,0,0, 1,2,1,11, 0, 1,0,0);
    applyStimulus("src1_go",      1,0,0,0, 1,2,1,11, 0, 0,0,0);
    applyStimulus("wr_r6",        1,1,6,0, 0,0,0,0, 0, 0,0,0);
    applyStimulus("flush_rd_r6",  1,0,0,0, 1,6,0,0, 1, 0,0,0);
    applyStimulus("after_flush",  1,0,0,0, 1,6,0,0, 0, 0,0,0);
    applyStimulus("after_flush2", 1,0,0,0, 1,6,0,0, 0, 0,0,0);
`endif

    // Reset while a stall is active.
    applyStimulus("wr_r12",       1,1,12,1, 0,0,0,0, 0, 0,0,0);
    applyStimulus("rd_r12_stall", 1,0,0,0, 1,12,0,0, 0, 1, FWD ? 2'd1 : 2'd0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    cntModel = 16'd0;
    pushExp("rst_mid_stall", 1'b0, 2'd0, 2'd0);
    -> checkNow;
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus("post_rst",     1,0,0,0, 1,12,0,0, 0, 0,0,0);
    applyStimulus("post_rst2",    1,0,0,0, 1,12,0,0, 0, 0,0,0);

    @(posedge clk);
    #1;
    issue_valid = 0; re0 = 0; re1 = 0;
    hlt = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
